// File: rtl/fb_pkg.sv
// Shared definitions for the RGB565 frame-buffer write path.
package fb_pkg;

    // Default RAM geometry: 17-bit word address, 16-bit RGB565 pixel.
    localparam int FB_AW = 17;
    localparam int FB_DW = 16;

    // Sequencer states, kept as plain constants so older code can compare raw bits.
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t CLEAR   = 2'd1;
    localparam state_t CAPTURE = 2'd2;

    // RGB565 field positions.
    localparam int RGB_R_HI = 15;
    localparam int RGB_R_LO = 11;
    localparam int RGB_G_HI = 10;
    localparam int RGB_G_LO = 5;
    localparam int RGB_B_HI = 4;
    localparam int RGB_B_LO = 0;

    // Build an RGB565 word from its three fields.
    function automatic logic [15:0] rgb565(input logic [4:0] r,
                                           input logic [5:0] g,
                                           input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/fb_byte_packer.sv
// Packs a camera byte stream (high byte first) into 16-bit pixels.
// A synchronous clear drops any held half pixel and returns to phase 0.
module fb_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_accept,
    output logic        pix_valid,
    output logic [15:0] pix_data
);

    logic       phase;
    logic [7:0] hi_byte;

    // Track the byte phase and hold the high byte until its partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'h00;
        end else if (clr) begin
            phase   <= 1'b0;
        end else if (byte_accept) begin
            if (!phase) begin
                hi_byte <= byte_in;
            end
            phase <= ~phase;
        end
    end

    // A pixel completes on an accepted phase-1 byte unless a restart discards it.
    assign pix_valid = byte_accept & phase & ~clr;
    assign pix_data  = {hi_byte, byte_in};

endmodule

// File: rtl/fb_write_ctrl.sv
// Write-port sequencer for the RGB565 frame buffer: packs camera bytes into
// pixels, writes them at sequential addresses, and clears the buffer on demand.
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int              AW        = FB_AW,
    parameter int              DW        = FB_DW,
    parameter int              PIX_COUNT = 76800,
    parameter logic [DW-1:0]   CLR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    input  logic          frame_start,
    input  logic [7:0]    px_byte,
    input  logic          px_byte_valid,
    output logic          px_ready,
    output logic          clear_busy,
    output logic          frame_done,
    output logic          dropped_frame,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite
);

    localparam logic [AW-1:0] LAST_PIX = AW'(PIX_COUNT - 1);

    state_t        state;
    logic [AW-1:0] pix_cnt;
    logic          byte_accept;
    logic          packer_clr;
    logic          pix_valid;
    logic [15:0]   pix_data;

    // Bytes are only taken while capturing; anything else on the bus is discarded.
    assign px_ready    = (state == CAPTURE);
    assign byte_accept = px_byte_valid & px_ready;
    // Keep the packer at phase 0 outside capture and on every frame restart.
    assign packer_clr  = frame_start | (state != CAPTURE);

    fb_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (packer_clr),
        .byte_in     (px_byte),
        .byte_accept (byte_accept),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data)
    );

    // Sequencer FSM, pixel counter and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            regwrite      <= 1'b0;
            addr_in       <= '0;
            data_in       <= '0;
            clear_busy    <= 1'b0;
            frame_done    <= 1'b0;
            dropped_frame <= 1'b0;
        end else begin
            // Write strobe and status pulses last one cycle unless re-armed below;
            // addr_in/data_in keep their last value between writes.
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
            clear_busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear_req) begin
                        // First clear write goes out in the very next cycle.
                        regwrite   <= 1'b1;
                        addr_in    <= '0;
                        data_in    <= CLR_COLOR;
                        clear_busy <= 1'b1;
                        if (LAST_PIX == '0) begin
                            pix_cnt <= '0;
                        end else begin
                            pix_cnt <= AW'(1);
                            state   <= CLEAR;
                        end
                        if (frame_start) begin
                            dropped_frame <= 1'b1;
                        end
                    end else if (frame_start) begin
                        pix_cnt <= '0;
                        state   <= CAPTURE;
                    end
                end

                CLEAR: begin
                    regwrite   <= 1'b1;
                    addr_in    <= pix_cnt;
                    data_in    <= CLR_COLOR;
                    clear_busy <= 1'b1;
                    if (pix_cnt == LAST_PIX) begin
                        pix_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                    if (frame_start) begin
                        dropped_frame <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (frame_start) begin
                        // Restart: the packer drops its half pixel in the same cycle.
                        pix_cnt <= '0;
                    end else if (pix_valid) begin
                        regwrite <= 1'b1;
                        addr_in  <= pix_cnt;
                        data_in  <= DW'(pix_data);
                        if (pix_cnt == LAST_PIX) begin
                            frame_done <= 1'b1;
                            pix_cnt    <= '0;
                            state      <= IDLE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    pix_cnt <= '0;
                end
            endcase
        end
    end

endmodule
